// File: rtl/pca_register_file_pkg.sv
// Shared PCA9685 register map constants, reset values and the per-address write policy.
// The I2C target and the register file both use this policy.
package pca_register_file_pkg;

    localparam logic [7:0] PCA_MODE1        = 8'h00;
    localparam logic [7:0] PCA_MODE2        = 8'h01;
    localparam logic [7:0] PCA_SUBADR1      = 8'h02;
    localparam logic [7:0] PCA_SUBADR2      = 8'h03;
    localparam logic [7:0] PCA_SUBADR3      = 8'h04;
    localparam logic [7:0] PCA_ALLCALLADR   = 8'h05;
    localparam logic [7:0] PCA_LED0_ON_L    = 8'h06;
    localparam logic [7:0] PCA_ALL_LED_ON_L = 8'hFA;
    localparam logic [7:0] PCA_ALL_LED_OFF_H = 8'hFD;
    localparam logic [7:0] PCA_PRE_SCALE    = 8'hFE;

    localparam logic [7:0] PCA_MODE1_RST      = 8'h11;
    localparam logic [7:0] PCA_MODE2_RST      = 8'h04;
    localparam logic [7:0] PCA_SUBADR1_RST    = 8'hE2;
    localparam logic [7:0] PCA_SUBADR2_RST    = 8'hE4;
    localparam logic [7:0] PCA_SUBADR3_RST    = 8'hE8;
    localparam logic [7:0] PCA_ALLCALLADR_RST = 8'hE0;
    localparam logic [7:0] PCA_LED_OFF_H_RST  = 8'h10;
    localparam logic [7:0] PCA_PRE_SCALE_RST  = 8'h1E;
    localparam logic [7:0] PCA_PRESCALE_MIN   = 8'h03;
    localparam logic [7:0] PCA_MODE1_RESTART  = 8'h80;

    // Blob bit indices: byte k bit b lives at k*8 + (7-b).
    localparam int unsigned PCA_MODE1_ALLCALL = 7;
    localparam int unsigned PCA_MODE1_SUB3    = 6;
    localparam int unsigned PCA_MODE1_SUB2    = 5;
    localparam int unsigned PCA_MODE1_SUB1    = 4;
    localparam int unsigned PCA_MODE1_SLEEP   = 3;
    localparam int unsigned PCA_MODE1_AI      = 2;

    typedef enum logic {
        BC_IDLE,
        BC_ACTIVE
    } bcast_state_e;

    typedef struct packed {
        logic       store_en;
        logic [7:0] value;
    } policy_t;

    function automatic logic pca_is_all_led(input logic [7:0] id);
        return (id >= PCA_ALL_LED_ON_L) && (id <= PCA_ALL_LED_OFF_H);
    endfunction

    function automatic policy_t pca_reg_policy(input logic [7:0] id, input logic [7:0] value,
                                               input logic sleep, input logic [7:0] last_stored);
        policy_t p;
        p.store_en = 1'b0;
        p.value    = value;
        if (id == PCA_MODE1) begin
            p.store_en = 1'b1;
            p.value    = value & ~PCA_MODE1_RESTART;
        end else if (id <= last_stored) begin
            p.store_en = 1'b1;
        end else if (id == PCA_PRE_SCALE) begin
            p.store_en = sleep && (value >= PCA_PRESCALE_MIN);
        end
        return p;
    endfunction

    function automatic logic [7:0] pca_reset_value(input logic [7:0] id, input logic [7:0] last_stored);
        logic [7:0] v;
        case (id)
            PCA_MODE1:      v = PCA_MODE1_RST;
            PCA_MODE2:      v = PCA_MODE2_RST;
            PCA_SUBADR1:    v = PCA_SUBADR1_RST;
            PCA_SUBADR2:    v = PCA_SUBADR2_RST;
            PCA_SUBADR3:    v = PCA_SUBADR3_RST;
            PCA_ALLCALLADR: v = PCA_ALLCALLADR_RST;
            PCA_PRE_SCALE:  v = PCA_PRE_SCALE_RST;
            default: begin
                // LEDn_OFF_H sits at 0x09+4n, i.e. address bits [1:0] == 2'b01.
                if (id >= PCA_LED0_ON_L && id <= last_stored && id[1:0] == 2'b01)
                    v = PCA_LED_OFF_H_RST;
                else
                    v = '0;
            end
        endcase
        return v;
    endfunction

endpackage

// File: rtl/pca_register_file_bcast_seq.sv
// ALL_LED broadcast sequencer: walks the channel index once per cycle while busy.
module pca_bcast_seq #(
    parameter int unsigned NUM_LEDS = 16,
    parameter int unsigned CW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          start_i,
    output logic          busy_o,
    output logic [CW-1:0] chan_o
);
    import pca_register_file_pkg::*;

    bcast_state_e  state_q, state_d;
    logic [CW-1:0] chan_q, chan_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= BC_IDLE;
            chan_q  <= '0;
        end else if (clr_i) begin
            state_q <= BC_IDLE;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
        end
    end

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        case (state_q)
            BC_IDLE: begin
                if (start_i) begin
                    state_d = BC_ACTIVE;
                    chan_d  = '0;
                end
            end
            BC_ACTIVE: begin
                if (chan_q == CW'(NUM_LEDS - 1))
                    state_d = BC_IDLE;
                else
                    chan_d = chan_q + CW'(1);
            end
            default: state_d = BC_IDLE;
        endcase
    end

    assign busy_o = (state_q == BC_ACTIVE);
    assign chan_o = chan_q;

endmodule

// File: rtl/pca_register_file.sv
// PCA9685-compatible 256-byte register store with write policy, ALL_LED broadcast and a
// one-entry pending slot for writes arriving while a broadcast is in progress.
module pca_register_file #(
    parameter int unsigned NUM_LEDS     = 16,
    parameter bit          BCAST_ENABLE = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          sw_reset_i,
    input  logic [7:0]    write_register_id_i,
    input  logic [7:0]    write_register_value_i,
    input  logic          write_enable_i,
    output logic [0:2047] register_blob_o,
    output logic [7:0]    prescale_o,
    output logic          sleep_o,
    output logic          busy_o,
    output logic          regs_changed_o,
    output logic          dropped_o
);
    import pca_register_file_pkg::*;

    localparam int unsigned CW          = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [7:0]  LAST_STORED = 8'(5 + 4 * NUM_LEDS);

    logic [7:0]    regs_q [256];
    logic          we_q, changed_q, dropped_q;
    logic          pend_v_q, pend_v_d;
    logic [7:0]    pend_id_q, pend_id_d, pend_val_q, pend_val_d;
    logic [1:0]    bc_k_q;
    logic [7:0]    bc_val_q;
    logic          bc_busy;
    logic [CW-1:0] bc_chan;
    logic          detect, act_v, drop, start, changed, wr_en;
    logic [7:0]    act_id, act_val, wr_addr, wr_data;
    policy_t       pol;

    assign detect = write_enable_i & ~we_q;

    // Select the write acted on this edge: a pending entry takes precedence over a fresh
    // detection, which then refills the slot being vacated.
    always_comb begin
        act_v      = 1'b0;
        act_id     = write_register_id_i;
        act_val    = write_register_value_i;
        pend_v_d   = pend_v_q;
        pend_id_d  = pend_id_q;
        pend_val_d = pend_val_q;
        drop       = 1'b0;
        if (bc_busy) begin
            if (detect) begin
                if (pend_v_q) begin
                    drop = 1'b1;
                end else begin
                    pend_v_d   = 1'b1;
                    pend_id_d  = write_register_id_i;
                    pend_val_d = write_register_value_i;
                end
            end
        end else if (pend_v_q) begin
            act_v    = 1'b1;
            act_id   = pend_id_q;
            act_val  = pend_val_q;
            pend_v_d = 1'b0;
            if (detect) begin
                pend_v_d   = 1'b1;
                pend_id_d  = write_register_id_i;
                pend_val_d = write_register_value_i;
            end
        end else if (detect) begin
            act_v = 1'b1;
        end
    end

    assign start = act_v & BCAST_ENABLE & pca_is_all_led(act_id);
    assign pol   = pca_reg_policy(act_id, act_val, sleep_o, LAST_STORED);

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = act_id;
        wr_data = pol.value;
        if (bc_busy) begin
            wr_en   = 1'b1;
            wr_addr = PCA_LED0_ON_L + (8'(bc_chan) << 2) + {6'd0, bc_k_q};
            wr_data = bc_val_q;
        end else if (act_v && pol.store_en) begin
            wr_en = 1'b1;
        end
    end

    assign changed = wr_en && (regs_q[wr_addr] != wr_data);

    pca_bcast_seq #(
        .NUM_LEDS (NUM_LEDS),
        .CW       (CW)
    ) u_bcast_seq (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (sw_reset_i),
        .start_i (start),
        .busy_o  (bc_busy),
        .chan_o  (bc_chan)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < 256; i++) regs_q[i] <= pca_reset_value(8'(i), LAST_STORED);
        end else if (sw_reset_i) begin
            for (int unsigned i = 0; i < 256; i++) regs_q[i] <= pca_reset_value(8'(i), LAST_STORED);
        end else if (wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q       <= 1'b0;
            changed_q  <= 1'b0;
            dropped_q  <= 1'b0;
            pend_v_q   <= 1'b0;
            pend_id_q  <= '0;
            pend_val_q <= '0;
            bc_k_q     <= '0;
            bc_val_q   <= '0;
        end else begin
            // Keeps tracking enable through a soft reset so a held level cannot retrigger.
            we_q <= write_enable_i;
            if (sw_reset_i) begin
                changed_q <= 1'b0;
                dropped_q <= 1'b0;
                pend_v_q  <= 1'b0;
            end else begin
                changed_q  <= changed;
                dropped_q  <= drop;
                pend_v_q   <= pend_v_d;
                pend_id_q  <= pend_id_d;
                pend_val_q <= pend_val_d;
                if (start) begin
                    bc_k_q   <= 2'(act_id - PCA_ALL_LED_ON_L);
                    bc_val_q <= act_val;
                end
            end
        end
    end

    for (genvar k = 0; k < 256; k++) begin : g_blob
        assign register_blob_o[k*8 +: 8] = regs_q[k];
    end

    assign prescale_o     = regs_q[PCA_PRE_SCALE];
    assign sleep_o        = register_blob_o[PCA_MODE1_SLEEP];
    assign busy_o         = bc_busy;
    assign regs_changed_o = changed_q;
    assign dropped_o      = dropped_q;

endmodule
